// File: rtl/cix32_store_buffer.sv
// Posted-write store buffer between the CIX-32 LSU physical memory port and
// the shared memory bus. Stores retire to the LSU in one cycle and drain to
// the bus in FIFO order. Loads that hit buffered stores are forwarded (full
// word) or stalled (partial word); other loads go to the bus ahead of pending
// drains unless the buffer is full or a fence is pending.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   lsu_req/we/addr/wdata/wstrb   LSU request, held until lsu_ready
//   lsu_ready, lsu_rdata          LSU completion and load data
//   bus_req/we/addr/wdata/wstrb   registered bus request
//   bus_ready, bus_rdata          bus completion and read data
//   fence_req, fence_done         drain-all handshake
//   empty, full                   buffer occupancy flags
module cix32_store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lsu_req,
  input  logic            lsu_we,
  input  logic [AW-1:0]   lsu_addr,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wstrb,
  output logic            lsu_ready,
  output logic [DW-1:0]   lsu_rdata,
  output logic            bus_req,
  output logic            bus_we,
  output logic [AW-1:0]   bus_addr,
  output logic [DW-1:0]   bus_wdata,
  output logic [DW/8-1:0] bus_wstrb,
  input  logic            bus_ready,
  input  logic [DW-1:0]   bus_rdata,
  input  logic            fence_req,
  output logic            fence_done,
  output logic            empty,
  output logic            full
);
  localparam int unsigned SW  = DW / 8;
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned WAW = AW - 2;

  typedef struct packed {
    logic [WAW-1:0] addr;
    logic [DW-1:0]  data;
    logic [SW-1:0]  strb;
  } entry_t;

  typedef enum logic [1:0] { S_IDLE, S_LOAD, S_DRAIN } state_t;

  entry_t        r_ent [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_bus_req;
  logic          r_bus_we;
  logic [AW-1:0] r_bus_addr;
  logic [DW-1:0] r_bus_wdata;
  logic [SW-1:0] r_bus_wstrb;
  logic          w_bus_req_nxt;
  logic          w_bus_we_nxt;
  logic [AW-1:0] w_bus_addr_nxt;
  logic [DW-1:0] w_bus_wdata_nxt;
  logic [SW-1:0] w_bus_wstrb_nxt;

  logic          w_empty;
  logic          w_full;
  logic          w_load;
  logic          w_store_acc;
  logic          w_hit;
  logic          w_hit_full;
  logic [DW-1:0] w_hit_data;
  logic          w_fwd;
  logic          w_load_done;
  logic          w_pop;
  entry_t        w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign empty   = w_empty;
  assign full    = w_full;
  assign w_head  = r_ent[r_head];

  assign w_load      = lsu_req && !lsu_we;
  // Store acceptance uses only registered occupancy; a same-cycle pop does not free a slot.
  assign w_store_acc = !rst && lsu_req && lsu_we && !w_full && !fence_req;
  assign w_load_done = (r_state == S_LOAD) && bus_ready && w_load;
  assign w_pop       = (r_state == S_DRAIN) && bus_ready;

  // Hazard scan from oldest to youngest; the last match seen is the youngest.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_full = 1'b0;
    w_hit_data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < r_count) &&
          (r_ent[PW'(r_head + PW'(k))].addr == lsu_addr[AW-1:2])) begin
        w_hit      = 1'b1;
        w_hit_full = &r_ent[PW'(r_head + PW'(k))].strb;
        w_hit_data = r_ent[PW'(r_head + PW'(k))].data;
      end
    end
  end

  assign w_fwd      = w_load && w_hit && w_hit_full && (r_state != S_LOAD);
  assign lsu_ready  = !rst && (w_store_acc || w_fwd || w_load_done);
  assign lsu_rdata  = rst         ? '0 :
                      w_load_done ? bus_rdata :
                      w_fwd       ? w_hit_data : '0;
  assign fence_done = !rst && fence_req && w_empty && (r_state == S_IDLE);

  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_wstrb = r_bus_wstrb;

  // Bus FSM next state; the bus payload is captured at the decision and held.
  always_comb begin
    w_state_nxt     = r_state;
    w_bus_req_nxt   = r_bus_req;
    w_bus_we_nxt    = r_bus_we;
    w_bus_addr_nxt  = r_bus_addr;
    w_bus_wdata_nxt = r_bus_wdata;
    w_bus_wstrb_nxt = r_bus_wstrb;
    case (r_state)
      S_IDLE: begin
        if (w_load && !w_hit && !w_full && !fence_req) begin
          w_state_nxt     = S_LOAD;
          w_bus_req_nxt   = 1'b1;
          w_bus_we_nxt    = 1'b0;
          w_bus_addr_nxt  = lsu_addr;
          w_bus_wdata_nxt = '0;
          w_bus_wstrb_nxt = '0;
        end else if (!w_empty) begin
          w_state_nxt     = S_DRAIN;
          w_bus_req_nxt   = 1'b1;
          w_bus_we_nxt    = 1'b1;
          w_bus_addr_nxt  = {w_head.addr, 2'b00};
          w_bus_wdata_nxt = w_head.data;
          w_bus_wstrb_nxt = w_head.strb;
        end
      end
      S_LOAD, S_DRAIN: begin
        if (bus_ready) begin
          w_state_nxt     = S_IDLE;
          w_bus_req_nxt   = 1'b0;
          w_bus_we_nxt    = 1'b0;
          w_bus_addr_nxt  = '0;
          w_bus_wdata_nxt = '0;
          w_bus_wstrb_nxt = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, bus registers, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_wstrb <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_bus_req   <= w_bus_req_nxt;
      r_bus_we    <= w_bus_we_nxt;
      r_bus_addr  <= w_bus_addr_nxt;
      r_bus_wdata <= w_bus_wdata_nxt;
      r_bus_wstrb <= w_bus_wstrb_nxt;
      if (w_store_acc) r_tail <= r_tail + PW'(1);
      if (w_pop)       r_head <= r_head + PW'(1);
      case ({w_store_acc, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; validity comes from head/count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_store_acc) r_ent[r_tail] <= '{addr: lsu_addr[AW-1:2], data: lsu_wdata, strb: lsu_wstrb};
  end

endmodule

// File: tb/tb_cix32_store_buffer.sv
// Bench for cix32_store_buffer: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_cix32_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req, lsu_we;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [3:0]  lsu_wstrb;
  logic        lsu_ready;
  logic [31:0] lsu_rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        fence_req, fence_done, empty, full;

  cix32_store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_ready(lsu_ready), .lsu_rdata(lsu_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .fence_req(fence_req), .fence_done(fence_done),
    .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int bus_mode = 0;              // 0 stall, 1 always ready, 2 random
  bit rdata_fix = 1'b0;
  logic [31:0] rdata_val = '0;

  typedef struct { logic [29:0] waddr; logic [31:0] data; logic [3:0] strb; } ent_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } xfer_t;
  ent_t  mq[$];
  xfer_t blog[$];
  bit          m_busy, m_wr;
  logic [31:0] m_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus responder.
  initial begin
    bus_ready = 1'b0;
    bus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      case (bus_mode)
        1:       bus_ready = 1'b1;
        2:       bus_ready = ($urandom_range(0, 2) == 0);
        default: bus_ready = 1'b0;
      endcase
      bus_rdata = rdata_fix ? rdata_val : $urandom;
    end
  end

  // Reference model: list of buffered stores plus the one bus transfer in flight.
  initial begin : model
    bit ld, hit, hfull, sacc, fwd, ldone, qfull, exp_rdy;
    logic [31:0] hdata, exp_rd;
    ent_t e;
    m_busy = 0; m_wr = 0; m_addr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mq.delete();
        m_busy = 0;
        m_wr   = 0;
        chk("rst_lsu_ready", 32'(lsu_ready), 0);
        chk("rst_lsu_rdata", lsu_rdata, 0);
        chk("rst_bus_req", 32'(bus_req), 0);
        chk("rst_bus_we", 32'(bus_we), 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_bus_wstrb", 32'(bus_wstrb), 0);
        chk("rst_fence_done", 32'(fence_done), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
      end else begin
        hit = 0; hfull = 0; hdata = '0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
          if (mq[i].waddr == lsu_addr[31:2]) begin
            hit = 1; hfull = (mq[i].strb == 4'hF); hdata = mq[i].data;
            break;
          end
        end
        qfull   = (mq.size() == DEPTH);
        ld      = lsu_req && !lsu_we;
        sacc    = lsu_req && lsu_we && !qfull && !fence_req;
        ldone   = m_busy && !m_wr && bus_ready && ld;
        fwd     = ld && hit && hfull && !(m_busy && !m_wr);
        exp_rdy = sacc || fwd || ldone;
        exp_rd  = ldone ? bus_rdata : (fwd ? hdata : 32'h0);
        chk("lsu_ready", 32'(lsu_ready), 32'(exp_rdy));
        chk("lsu_rdata", lsu_rdata, exp_rd);
        chk("bus_req", 32'(bus_req), 32'(m_busy));
        chk("fence_done", 32'(fence_done), 32'(fence_req && mq.size() == 0 && !m_busy));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("full", 32'(full), 32'(qfull));
        if (m_busy) begin
          chk("bus_we", 32'(bus_we), 32'(m_wr));
          if (m_wr) begin
            chk("bus_waddr", bus_addr, {mq[0].waddr, 2'b00});
            chk("bus_wdata", bus_wdata, mq[0].data);
            chk("bus_wstrb", 32'(bus_wstrb), 32'(mq[0].strb));
          end else begin
            chk("bus_raddr", bus_addr, m_addr);
          end
        end
        if (bus_req && bus_ready)
          blog.push_back('{we: bus_we, addr: bus_addr, data: (bus_we ? bus_wdata : bus_rdata)});
        // Advance to the next clock edge.
        if (m_busy) begin
          if (bus_ready) begin
            if (m_wr) void'(mq.pop_front());
            m_busy = 0;
          end
        end else if (ld && !hit && !qfull && !fence_req) begin
          m_busy = 1; m_wr = 0; m_addr = lsu_addr;
        end else if (mq.size() > 0) begin
          m_busy = 1; m_wr = 1;
        end
        if (sacc) begin
          e.waddr = lsu_addr[31:2]; e.data = lsu_wdata; e.strb = lsu_wstrb;
          mq.push_back(e);
        end
      end
    end
  end

  // Issue one LSU request and hold it until lsu_ready; lat counts waited cycles.
  task automatic do_op(input logic we, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, output int lat, output logic [31:0] rd);
    bit got = 0;
    lat = 0; rd = '0;
    lsu_req = 1; lsu_we = we; lsu_addr = addr; lsu_wdata = data; lsu_wstrb = strb;
    while (!got && lat < 300) begin
      @(negedge clk);
      if (lsu_ready) begin got = 1; rd = lsu_rdata; end
      @(posedge clk); #1;
      if (!got) lat++;
    end
    lsu_req = 0;
    chk("lsu_timeout", 32'(got), 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    bit ok = 0;
    while (!ok && n < 400) begin
      @(negedge clk);
      ok = empty && !bus_req;
      @(posedge clk); #1;
      n++;
    end
    chk(name, 32'(ok), 1);
  endtask

  task automatic do_fence(input string name, output bit e_at, output int n_at);
    int n = 0;
    bit ok = 0;
    e_at = 0; n_at = 0;
    fence_req = 1;
    while (!ok && n < 400) begin
      @(negedge clk);
      if (fence_done) begin ok = 1; e_at = empty; n_at = blog.size(); end
      @(posedge clk); #1;
      n++;
    end
    fence_req = 0;
    chk(name, 32'(ok), 1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat, n, nfd;
    logic [31:0] rd;
    bit ok, e_at;
    rst = 1; lsu_req = 0; lsu_we = 0; lsu_addr = '0; lsu_wdata = '0; lsu_wstrb = '0;
    fence_req = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_empty", 32'(empty), 1);
    chk("reset_bus_req", 32'(bus_req), 0);
    @(posedge clk); #1;
    rst = 0;

    // Reset while a drain is stalled on the bus.
    bus_mode = 0;
    do_op(1, 32'h100, 32'hDEADBEEF, 4'hF, lat, rd);
    chk("t1_store_lat", lat, 0);
    n = 0; ok = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      if (bus_req) begin
        ok = 1;
        chk("t1_bus_addr", bus_addr, 32'h100);
        chk("t1_bus_wdata", bus_wdata, 32'hDEADBEEF);
        chk("t1_bus_we", 32'(bus_we), 1);
      end
      @(posedge clk); #1;
      n++;
    end
    chk("t1_bus_req_seen", 32'(ok), 1);
    @(posedge clk); #2;
    rst = 1;
    #1 chk("t1_async_bus_req", 32'(bus_req), 0);
    @(posedge clk); #1;
    rst = 0;
    blog.delete();
    bus_mode = 1;
    repeat (8) begin @(posedge clk); #1; end
    chk("t1_no_write", blog.size(), 0);
    @(negedge clk);
    chk("t1_empty", 32'(empty), 1);
    @(posedge clk); #1;

    // Fill to DEPTH with the bus stalled, fifth store waits for a pop.
    blog.delete(); bus_mode = 0;
    for (int i = 0; i < 4; i++) begin
      do_op(1, 32'h1000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF, lat, rd);
      chk("t2_fill_lat", lat, 0);
    end
    @(negedge clk);
    chk("t2_full", 32'(full), 1);
    @(posedge clk); #1;
    fork
      do_op(1, 32'h1010, 32'hA000_0004, 4'hF, lat, rd);
      begin repeat (3) @(posedge clk); #1; bus_mode = 1; end
    join
    chk("t2_fifth_waited", 32'(lat > 0), 1);
    wait_idle("t2_drain");
    chk("t2_nwrites", blog.size(), 5);
    for (int i = 0; i < 5 && i < blog.size(); i++) begin
      chk("t2_order_addr", blog[i].addr, 32'h1000 + 32'(4 * i));
      chk("t2_order_data", blog[i].data, 32'hA000_0000 + 32'(i));
    end

    // Full-word forward.
    blog.delete(); bus_mode = 0;
    do_op(1, 32'h200, 32'h12345678, 4'hF, lat, rd);
    do_op(0, 32'h202, 32'h0, 4'h0, lat, rd);
    chk("t3_fwd_lat", lat, 0);
    chk("t3_fwd_data", rd, 32'h12345678);
    bus_mode = 1;
    wait_idle("t3_drain");
    chk("t3_nxfers", blog.size(), 1);
    if (blog.size() > 0) chk("t3_only_write", 32'(blog[0].we), 1);

    // Partial-word hazard stalls until the write drains.
    blog.delete(); bus_mode = 0; rdata_fix = 1; rdata_val = 32'hCAFE0011;
    do_op(1, 32'h300, 32'h0000BEEF, 4'b0011, lat, rd);
    fork
      do_op(0, 32'h300, 32'h0, 4'h0, lat, rd);
      begin repeat (4) @(posedge clk); #1; bus_mode = 1; end
    join
    chk("t4_stalled", 32'(lat > 0), 1);
    chk("t4_rdata", rd, 32'hCAFE0011);
    wait_idle("t4_drain");
    rdata_fix = 0;
    chk("t4_nxfers", blog.size(), 2);
    if (blog.size() == 2) begin
      chk("t4_first_write", {31'(0), blog[0].we}, 1);
      chk("t4_first_addr", blog[0].addr, 32'h300);
      chk("t4_then_read", {31'(0), blog[1].we}, 0);
      chk("t4_read_addr", blog[1].addr, 32'h300);
    end

    // Load bypasses buffered stores once the in-flight write completes.
    blog.delete(); bus_mode = 0;
    do_op(1, 32'h3F0, 32'h11111111, 4'hF, lat, rd);
    do_op(1, 32'h400, 32'h22222222, 4'hF, lat, rd);
    do_op(1, 32'h404, 32'h33333333, 4'hF, lat, rd);
    fork
      do_op(0, 32'h500, 32'h0, 4'h0, lat, rd);
      begin repeat (3) @(posedge clk); #1; bus_mode = 1; end
    join
    wait_idle("t5_drain");
    chk("t5_nxfers", blog.size(), 4);
    if (blog.size() == 4) begin
      chk("t5_w3f0", blog[0].addr, 32'h3F0);
      chk("t5_read_we", {31'(0), blog[1].we}, 0);
      chk("t5_read_addr", blog[1].addr, 32'h500);
      chk("t5_w400", blog[2].addr, 32'h400);
      chk("t5_w404", blog[3].addr, 32'h404);
    end

    // Fence across pointer wrap.
    blog.delete(); bus_mode = 1;
    for (int i = 0; i < 6; i++) do_op(1, 32'h600 + 32'(4 * i), 32'hB000_0000 + 32'(i), 4'hF, lat, rd);
    wait_idle("t6_pre_drain");
    bus_mode = 0;
    for (int i = 6; i < 8; i++) do_op(1, 32'h600 + 32'(4 * i), 32'hB000_0000 + 32'(i), 4'hF, lat, rd);
    fence_req = 1;
    lsu_req = 1; lsu_we = 1; lsu_addr = 32'h700; lsu_wdata = 32'h0; lsu_wstrb = 4'hF;
    @(negedge clk);
    chk("t6_store_refused", 32'(lsu_ready), 0);
    chk("t6_not_done", 32'(fence_done), 0);
    @(posedge clk); #1;
    lsu_req = 0;
    bus_mode = 1;
    do_fence("t6_fence_done", e_at, nfd);
    chk("t6_empty_at_done", 32'(e_at), 1);
    chk("t6_writes_before_done", nfd, 8);
    for (int i = 0; i < 8 && i < blog.size(); i++)
      chk("t6_order", blog[i].addr, 32'h600 + 32'(4 * i));

    // Random traffic against the model.
    bus_mode = 2;
    repeat (600) begin
      if ($urandom_range(0, 99) < 4) begin
        do_fence("rnd_fence", e_at, nfd);
      end else begin
        do_op(1'($urandom_range(0, 1)),
              32'h800 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)),
              $urandom,
              ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom),
              lat, rd);
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
    bus_mode = 1;
    wait_idle("final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cix32_store_buffer.md
Name: cix32_store_buffer

Overview:
- Posted-write buffer between the CIX-32 load/store unit's physical memory interface and the shared memory bus.
- Retires stores to the LSU in one cycle and drains them to the bus in FIFO order.
- Forwards or stalls loads that hit buffered stores; otherwise sends loads to the bus ahead of pending drains.
- Provides a fence (drain-all) handshake for serialising instructions.

Parameters:
DEPTH, 4, number of store entries (power of two, >=2)
AW, 32, address width
DW, 32, data width (byte strobes = DW/8)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
lsu_req  in  1  request from LSU, held until lsu_ready
lsu_we  in  1  1=store, 0=load
lsu_addr  in  AW  physical byte address
lsu_wdata  in  DW  store data
lsu_wstrb  in  DW/8  store byte strobes
lsu_ready  out  1  request completes this cycle
lsu_rdata  out  DW  load data, valid when lsu_ready & !lsu_we
bus_req  out  1  bus request
bus_we  out  1  bus write
bus_addr  out  AW  bus address
bus_wdata  out  DW  bus write data
bus_wstrb  out  DW/8  bus byte strobes
bus_ready  in  1  bus completes the transfer this cycle
bus_rdata  in  DW  bus read data
fence_req  in  1  drain request, held until fence_done
fence_done  out  1  buffer empty and bus idle while fence_req=1
empty  out  1  no buffered stores
full  out  1  count == DEPTH

Behaviour:
- Reset (rst=1, any cycle, async): all entries invalid, count=0, state IDLE.
  - Outputs: lsu_ready=0, bus_req=0, bus_we=0, bus_addr/wdata/wstrb=0, lsu_rdata=0, fence_done=0, empty=1, full=0.
  - A bus transfer in flight is abandoned; no completion is reported.
- Entry fields: addr[AW-1:2] word address, data, strb. FIFO order uses head and tail pointers plus a count of width clog2(DEPTH)+1.
- Store accept:
  - Condition: lsu_req & lsu_we & !full (evaluated on registered count) & !fence_req.
  - Effect: lsu_ready=1 combinationally, and the entry is enqueued at the clock edge.
  - Full: lsu_ready=0 until the next cycle with count<DEPTH. A pop in the same cycle does not free a slot for that cycle.
- Load hazard check, combinational against every valid entry, matching lsu_addr[AW-1:2]:
  - No match: load is eligible for the bus.
  - Youngest match has strb == all-ones: forward. lsu_ready=1 and lsu_rdata=entry data in the same cycle, with no bus access.
  - Youngest match has a partial strb: stall (lsu_ready=0) until no matching entry remains, then treat as no match.
- Bus FSM states: IDLE, LOAD, DRAIN.
  - IDLE -> LOAD: an eligible no-match load is pending and neither full nor fence_req holds.
  - IDLE -> DRAIN: otherwise, when count>0.
  - LOAD: bus_req=1, bus_we=0, bus_addr=lsu_addr. On bus_ready: lsu_ready=1, lsu_rdata=bus_rdata (same-cycle pass-through), -> IDLE.
  - DRAIN: bus_req=1, bus_we=1, with head addr (low 2 bits 0), data and strb. On bus_ready: pop head, -> IDLE.
  - Entering a state from IDLE costs one cycle; bus_req first asserts the cycle after the decision.
- Bus stability: while bus_req=1 and bus_ready=0, bus_addr, bus_wdata, bus_wstrb and bus_we hold constant.
- Bus drive: bus_req is registered, never combinational from lsu_req.
- Priority when full or fence_req: drain first. Loads still forward or stall, but no load bus access until count<DEPTH.
- Fence: fence_done=1 when fence_req & count==0 & state==IDLE. New stores are refused while fence_req=1.
- Simultaneous pop (drain complete) and push (store accept) in the same cycle: count unchanged; both pointers advance modulo DEPTH.
- Pointer wrap: the pointer after index DEPTH-1 is 0.
- empty is count==0 and full is count==DEPTH, both registered-derived.
- lsu_rdata=0 whenever it is not valid.

Test Plan:
- Reset mid-drain: store 0x100 <- 0xDEADBEEF, assert rst while bus_req=1 and bus_ready=0 -> bus_req=0 in the same cycle (async); after release empty=1 and no write is issued.
- Fill: 5 stores with DEPTH=4 and bus_ready=0 -> first 4 get lsu_ready the same cycle and full=1; 5th waits until the first bus_ready pop, then is accepted the following cycle; bus writes appear in order.
- Forward: store 0x200 <- 0x12345678 (strb F), then load 0x202 -> lsu_ready the same cycle, lsu_rdata=0x12345678, no bus_req with bus_we=0.
- Partial hazard: store 0x300 strb 4'b0011, then load 0x300 -> lsu_ready=0 until the write completes; then the bus read completes with bus_rdata=0xCAFE0011 returned.
- Load bypass: 2 buffered stores to 0x400 and 0x404, load 0x500 -> bus read issued before both writes; writes then drain to 0x400 then 0x404.
- Fence with wrap: push/pop 6 stores through DEPTH=4, assert fence_req -> stores refused; fence_done=1 only after the last write's bus_ready and the return to IDLE; order preserved across pointer wrap.
